// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor. One full-adder slice and a
// carry flop walk the operands LSB-first over WIDTH cycles; the result is
// announced with a one-cycle done pulse.
// Optional build macro SERIAL_ADD_SUB_SAT_EN: signed saturation of the
// result on overflow, using the sign of operand A captured at start.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sub_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             b_eff;
  logic             sum_bit;
  logic             carry_nxt;
  logic             last;
  logic             accept;
`ifdef SERIAL_ADD_SUB_SAT_EN
  logic             a_msb;
`endif

  // Full-adder slice on the current LSBs plus handshake decodes.
  always_comb begin
    b_eff     = b_sh[0] ^ sub_q;
    sum_bit   = a_sh[0] ^ b_eff ^ carry;
    carry_nxt = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
    last      = (state == RUN) && (cnt == LAST_BIT);
    accept    = (state == IDLE) && start;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave IDLE on an accepted start, return after the MSB.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: busy is exactly the RUN state.
  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      RUN:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: operand load, per-bit shift/accumulate, and final flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ADD_SUB_SAT_EN
      a_msb  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sub_q  <= sub;
      // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
      carry  <= sub;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ADD_SUB_SAT_EN
      a_msb  <= a[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      if (last) begin
        done <= 1'b1;
        cout <= carry_nxt;
        // Carry into the MSB is the carry flop while the MSB is processed.
        ovf  <= carry ^ carry_nxt;
`ifdef SERIAL_ADD_SUB_SAT_EN
        if (carry ^ carry_nxt) begin
          result <= {a_msb, {(WIDTH-1){~a_msb}}};
        end else begin
          result <= {sum_bit, result[WIDTH-1:1]};
        end
`else
        result <= {sum_bit, result[WIDTH-1:1]};
`endif
      end else begin
        done   <= 1'b0;
        result <= {sum_bit, result[WIDTH-1:1]};
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized and directed stimulus for serial_add_sub,
// checked every cycle against a transaction-level model that computes the
// arithmetic result directly with integer math.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: returns {ovf, cout, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    logic [W:0] full;
    longint sx, sy, sr, smax, smin;
    logic o;
    logic [W-1:0] r;
    full = {1'b0, x} + (s ? {1'b0, ~y} : {1'b0, y}) + {{W{1'b0}}, s};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = s ? (sx - sy) : (sx + sy);
    smax = (64'sd1 <<< (W - 1)) - 64'sd1;
    smin = -(64'sd1 <<< (W - 1));
    o = (sr > smax) || (sr < smin);
    r = full[W-1:0];
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (sr > smax) r = smax[W-1:0];
    else if (sr < smin) r = smin[W-1:0];
`endif
    return {o, full[W], r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Transaction model state.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit [W-1:0]   m_res = '0;
  bit           m_cout = 1'b0;
  bit           m_ovf = 1'b0;
  int           m_left = 0;
  bit [W+1:0]   m_pend = '0;

  // Model: an accepted op finishes WIDTH edges later with precomputed values.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0;
      m_cout <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_ovf  <= m_pend[W+1];
          m_cout <= m_pend[W];
          m_res  <= m_pend[W-1:0];
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= W;
        m_pend <= ref_op(a, b, sub);
        m_res  <= '0;
        m_cout <= 1'b0;
        m_ovf  <= 1'b0;
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("cout", cout, m_cout);
      chk("ovf", ovf, m_ovf);
      if (!m_busy) chk("result", result, m_res);
    end
  end

  // Issue one op (call at a negedge), wait bounded for done, check literals.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input bit poke);
    int n;
    int bc;
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bc = 0;
    while (!done && n < 4 * W) begin
      if (busy) bc++;
      if (poke && n == 3) begin
        a = ~x; b = ~y; sub = ~s; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("op_done_seen", done, 1'b1);
    chk("op_latency", n - 1, W);
    chk("op_busy_cycles", bc, W);
    chk("op_result", result, er);
    chk("op_cout", cout, ec);
    chk("op_ovf", ovf, eo);
  endtask

  logic [W-1:0] sat_pos;
  logic [W-1:0] sat_neg;
  logic [W+1:0] exp_v;

  initial begin
    sat_pos = 8'h80;
    sat_neg = 8'h7F;
`ifdef SERIAL_ADD_SUB_SAT_EN
    sat_pos = 8'h7F;
    sat_neg = 8'h80;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed values.
    do_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, sat_pos, 1'b0, 1'b1, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    do_op(8'h80, 8'h01, 1'b1, sat_neg, 1'b1, 1'b1, 1'b0);

    // Reset mid-run: aborts op, clears outputs, no done.
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 8'h00);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 1'b0);
    end

    // Randomized ops, some with ignored starts during busy, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      logic s;
      int gap;
      x = W'($urandom);
      y = W'($urandom);
      s = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      exp_v = ref_op(x, y, s);
      do_op(x, y, s, exp_v[W-1:0], exp_v[W], exp_v[W+1], bit'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor: one full-adder slice plus a carry flop, iterated LSB-first over WIDTH cycles.
- Operands are loaded on a start handshake; the result is delivered with a one-cycle done pulse.
- Sits beside the combinational ripple adder/subtractor modules as the area-optimised, sequential member of the family.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only when busy=0.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; bit counter and shift registers cleared.
- Reset applied mid-operation aborts the operation. No done is produced. The previous result is lost (cleared to 0).
- FSM states: IDLE, RUN.
  - IDLE: start=1 at edge k loads a, b, sub into shift registers. At the same edge: carry flop := sub, counter := 0, result := 0, cout := 0, ovf := 0, state := RUN, busy := 1.
  - RUN: at each edge k+1+i (i=0..WIDTH-1), the slice computes bit i:
    - s = a[i] ^ (b[i]^sub) ^ c
    - c' = majority(a[i], b[i]^sub, c)
    - s shifts into result from the MSB end; c' replaces c.
  - At edge k+WIDTH (last bit):
    - state := IDLE, busy := 0, done := 1.
    - cout := final carry.
    - ovf := carry-into-MSB XOR carry-out-of-MSB. The carry into the MSB is captured at bit WIDTH-1.
- done is high for exactly one cycle (cycle after edge k+WIDTH). It is cleared at the next edge unless a new operation completes.
- Latency: WIDTH cycles from start-accept edge to done; busy high for exactly WIDTH cycles.
- start while busy=1 is ignored; operands are not resampled.
- start asserted in the done cycle (busy=0) is accepted: back-to-back throughput of one op per WIDTH cycles.
- result, cout, ovf are stable from the done edge until the next accepted start. On that start they clear to 0.
- Arithmetic is modulo 2^WIDTH. cout and ovf are always both computed, independent of signedness interpretation.

Optional Feature:
- Macro: SERIAL_ADD_SUB_SAT_EN.
- Defined: signed saturation is applied at the done edge.
  - If ovf=1 and the MSB of a sampled operand A is 0, result := 0x7F..F (max positive).
  - If ovf=1 and the MSB of A is 1, result := 0x80..0 (min negative).
  - ovf still reports 1; cout is unchanged.
  - The MSB of A is kept in a dedicated flop captured at start.
- Not defined: result is always the wrapped modulo value; no extra flop.

Test Plan:
- WIDTH=8, start with a=0x05, b=0x03, sub=0:
  - busy high 8 cycles; done pulse 8 cycles after accept.
  - result=0x08, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, ovf=1 (with SERIAL_ADD_SUB_SAT_EN: result=0x7F).
- a=0x05, b=0x07, sub=1 -> result=0xFE, cout=0 (borrow), ovf=0.
- a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1 (SAT_EN: result=0x80).
- Control sequence:
  - Pulse start again during busy with different operands -> ignored.
  - Assert start in the done cycle -> second op accepted, done exactly 8 cycles later.
  - Assert rst_n=0 for one edge mid-RUN -> busy=0, done never pulses, all outputs 0 next cycle.
